oam_dma_engine: RTL and testbench
=================================

Name: oam_dma_engine

Overview:
- Game Boy OAM DMA master. Snoops CPU-side IO register writes for the DMA register (0xFF46).
- On a write to that register, copies LENGTH bytes from {value,8'h00} to DEST_BASE (OAM).
- Drives the memory router's RDMA read port and WDMA write port, directly upstream of the router.
- Raises O_DMA_ACTIVE so CPU-side logic can block non-HRAM accesses while a copy is in progress.

Parameters:
DMA_REG_ADDR, 16'hFF46, IO address that triggers a transfer
DEST_BASE, 16'hFE00, first destination address (OAM)
LENGTH, 160, bytes per transfer (1..256)
START_DELAY, 1, idle cycles between trigger and first read (1..15)

Ports:
I_CLK  in  1  system clock
I_RESET  in  1  asynchronous active-high reset
I_IOREG_ADDR  in  16  snooped IO bus address
I_IOREG_DATA  in  8  snooped IO bus write data
I_IOREG_WE_L  in  1  snooped IO write strobe, active low
O_DMA_REG  out  8  last value written to DMA_REG_ADDR (readback)
O_RDMA_ADDR  out  16  router RDMA address
O_RDMA_RE_L  out  1  router RDMA read enable, active low
I_RDMA_DATA  in  8  router RDMA read data; valid the cycle after RE_L was low
O_WDMA_ADDR  out  16  router WDMA address
O_WDMA_DATA  out  8  router WDMA write data
O_WDMA_WE_L  out  1  router WDMA write enable, active low
O_DMA_ACTIVE  out  1  high while a transfer is in progress
O_DMA_DONE  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (async, I_RESET high): state IDLE; O_DMA_REG=0; RE_L=WE_L=1; addresses=0; O_WDMA_DATA=0; O_DMA_ACTIVE=0; O_DMA_DONE=0; counters=0. An in-flight transfer is abandoned with no further strobes.
- Trigger: at the posedge where I_IOREG_WE_L=0 and I_IOREG_ADDR==DMA_REG_ADDR:
  - O_DMA_REG<=I_IOREG_DATA.
  - src_hi<=I_IOREG_DATA; values 0xE0–0xFF map to value-0x20 (echo RAM).
  - State<=START.
- States: IDLE -> START (START_DELAY cycles) -> XFER (LENGTH read cycles; writes overlap) -> DRAIN (2 cycles, last writes) -> DONE (1 cycle) -> IDLE.
- Read side, rd_idx 0..LENGTH-1, one per XFER cycle:
  - RE_L=0 and O_RDMA_ADDR={src_hi,8'h00}+rd_idx, 16-bit wrapping add.
- Data path: data for a read issued in cycle c is valid in c+1 and captured at the end of c+1.
- Write side, in c+2: WE_L=0, O_WDMA_ADDR=DEST_BASE+wr_idx, O_WDMA_DATA=captured byte.
- Pipeline depth 2; one byte written per cycle at steady state.
- Timing, trigger edge = cycle 0, START_DELAY=1:
  - START in cycle 1.
  - Reads in cycles 2..LENGTH+1.
  - Writes in cycles 4..LENGTH+3.
  - DONE pulse in cycle LENGTH+4.
  - O_DMA_ACTIVE high in cycles 1..LENGTH+3, low from the DONE cycle.
- Outside active strobe cycles, RE_L/WE_L=1; addresses and data hold their last values.
- Retrigger mid-transfer (any non-IDLE state):
  - Pipeline flushed; in-flight captured data is discarded and not written.
  - Restarts at START with the new source; rd_idx=wr_idx=0.
  - O_DMA_ACTIVE stays high; no DONE pulse for the aborted transfer.
- Trigger in the DONE cycle: DONE still pulses; next cycle is START.
- No two pulses of RE_L/WE_L ever target the same index twice within one transfer; exactly LENGTH writes per completed transfer.
- Writes to other IO addresses are ignored; IO reads are not snooped.

Test Plan:
- Reset mid-XFER (at write index 50) -> all outputs return to reset values asynchronously; no strobes until the next trigger.
- Write 0xC1 to 0xFF46; router model returns byte = low address byte ^ 0x5A:
  - -> 160 writes FE00..FE9F with data (i ^ 0x5A).
  - -> first read addr C100 in cycle 2; first write in cycle 4; DONE in cycle 164.
- Write 0xE3 -> reads start at 0xC300 (echo mapping); O_DMA_REG reads 0xE3.
- Retrigger with 0x80 at read index 20 -> no write for indices ≥ the flushed ones; new sequence reads 0x8000.. and writes FE00..FE9F; single DONE pulse.
- Write 0x12 to 0xFF47 and CPU read of 0xFF46 -> no transfer; O_DMA_ACTIVE stays 0.
- LENGTH=4, START_DELAY=3, source 0xFF:
  - -> reads DF00..DF03 in cycles 4..7; writes in cycles 6..9; DONE in cycle 10.

Source files
------------

// File: rtl/oam_dma_engine_if.sv
// Bus bundle between the OAM DMA engine and its neighbours: the snooped CPU
// IO write port, the router RDMA read port, the router WDMA write port and
// the status outputs.
interface oam_dma_engine_if;
  logic [15:0] I_IOREG_ADDR;
  logic [7:0]  I_IOREG_DATA;
  logic        I_IOREG_WE_L;
  logic [7:0]  O_DMA_REG;
  logic [15:0] O_RDMA_ADDR;
  logic        O_RDMA_RE_L;
  logic [7:0]  I_RDMA_DATA;
  logic [15:0] O_WDMA_ADDR;
  logic [7:0]  O_WDMA_DATA;
  logic        O_WDMA_WE_L;
  logic        O_DMA_ACTIVE;
  logic        O_DMA_DONE;

  modport master (
    input  I_IOREG_ADDR, I_IOREG_DATA, I_IOREG_WE_L, I_RDMA_DATA,
    output O_DMA_REG, O_RDMA_ADDR, O_RDMA_RE_L, O_WDMA_ADDR, O_WDMA_DATA,
           O_WDMA_WE_L, O_DMA_ACTIVE, O_DMA_DONE
  );

  modport slave (
    output I_IOREG_ADDR, I_IOREG_DATA, I_IOREG_WE_L, I_RDMA_DATA,
    input  O_DMA_REG, O_RDMA_ADDR, O_RDMA_RE_L, O_WDMA_ADDR, O_WDMA_DATA,
           O_WDMA_WE_L, O_DMA_ACTIVE, O_DMA_DONE
  );
endinterface

// File: rtl/oam_dma_engine.sv
// Game Boy OAM DMA master. A snooped write to the DMA register copies LENGTH
// bytes from {value,8'h00} into OAM through the router's RDMA/WDMA ports.
// Read data returns one cycle after the read strobe and is written the cycle
// after that, so reads and writes overlap with a two-deep pipeline.
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DEST_BASE    = 16'hFE00,
  parameter int          LENGTH       = 160,
  parameter int          START_DELAY  = 1
) (
  input logic              I_CLK,
  input logic              I_RESET,
  oam_dma_engine_if.master bus
);
  localparam int         STAGES   = 2;
  localparam logic [8:0] LAST_RD  = 9'(LENGTH);
  localparam logic [3:0] LAST_DLY = 4'(START_DELAY - 1);

  typedef enum logic [2:0] {IDLE, START, XFER, DRAIN, DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      dly, dly_n;
  logic [8:0]      rd_idx, rd_idx_n, wr_idx, wr_idx_n;
  logic [7:0]      src_hi, src_hi_n, dma_reg, dma_reg_n, wr_data, wr_data_n;
  logic [15:0]     rd_addr, rd_addr_n, wr_addr, wr_addr_n;
  // [0] read strobe this cycle, [1] read data on the bus, [2] write strobe
  logic [STAGES:0] vld_pipe, vld_pipe_n;
  logic            trig, issue;

  // State, counters and registered bus outputs
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state    <= IDLE;
      dly      <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      src_hi   <= '0;
      dma_reg  <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      vld_pipe <= '0;
    end else begin
      state    <= state_n;
      dly      <= dly_n;
      rd_idx   <= rd_idx_n;
      wr_idx   <= wr_idx_n;
      src_hi   <= src_hi_n;
      dma_reg  <= dma_reg_n;
      rd_addr  <= rd_addr_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      vld_pipe <= vld_pipe_n;
    end
  end

  // Next-state, read issue, write capture and trigger/flush handling
  always_comb begin
    state_n   = state;
    dly_n     = dly;
    rd_idx_n  = rd_idx;
    wr_idx_n  = wr_idx;
    src_hi_n  = src_hi;
    dma_reg_n = dma_reg;
    rd_addr_n = rd_addr;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    issue     = 1'b0;
    trig      = !bus.I_IOREG_WE_L && (bus.I_IOREG_ADDR == DMA_REG_ADDR);

    case (state)
      IDLE:  ;
      START: if (dly == LAST_DLY) begin
               state_n = XFER;
               issue   = 1'b1;
             end else begin
               dly_n = dly + 4'd1;
             end
      // rd_idx counts reads already issued; stop once all LENGTH are out
      XFER:  if (rd_idx == LAST_RD) begin
               state_n = DRAIN;
               dly_n   = '0;
             end else begin
               issue = 1'b1;
             end
      DRAIN: if (dly == 4'd1) state_n = DONE;
             else dly_n = dly + 4'd1;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (issue) begin
      rd_addr_n = {src_hi, 8'h00} + {7'd0, rd_idx};
      rd_idx_n  = rd_idx + 9'd1;
    end

    if (vld_pipe[1]) begin
      wr_data_n = bus.I_RDMA_DATA;
      wr_addr_n = DEST_BASE + {7'd0, wr_idx};
      wr_idx_n  = wr_idx + 9'd1;
    end

    vld_pipe_n = {vld_pipe[STAGES-1:0], issue};

    // A trigger restarts from any state; in-flight bytes are dropped and the
    // outputs keep their last values since no strobe accompanies them.
    if (trig) begin
      dma_reg_n  = bus.I_IOREG_DATA;
      src_hi_n   = (bus.I_IOREG_DATA >= 8'hE0) ? bus.I_IOREG_DATA - 8'h20
                                               : bus.I_IOREG_DATA;
      state_n    = START;
      dly_n      = '0;
      rd_idx_n   = '0;
      wr_idx_n   = '0;
      rd_addr_n  = rd_addr;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      vld_pipe_n = '0;
    end
  end

  assign bus.O_DMA_REG    = dma_reg;
  assign bus.O_RDMA_ADDR  = rd_addr;
  assign bus.O_RDMA_RE_L  = !vld_pipe[0];
  assign bus.O_WDMA_ADDR  = wr_addr;
  assign bus.O_WDMA_DATA  = wr_data;
  assign bus.O_WDMA_WE_L  = !vld_pipe[STAGES];
  assign bus.O_DMA_ACTIVE = (state == START) || (state == XFER) || (state == DRAIN);
  assign bus.O_DMA_DONE   = (state == DONE);
endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: a default instance (160 bytes, delay 1)
// and a short instance (4 bytes, delay 3), each behind a router model that
// returns (low address byte ^ 0x5A) one cycle after a read strobe.
module tb_oam_dma_engine;
  typedef struct {int c; logic [15:0] a; logic [7:0] d;} ev_t;

  logic clk, rst;
  int   cyc, t0, t1, n_chk, n_err, act_a;
  ev_t  rda[$], wra[$], rdb[$], wrb[$];
  int   dna[$], dnb[$];

  oam_dma_engine_if ia();
  oam_dma_engine_if ib();

  oam_dma_engine dut_a (.I_CLK(clk), .I_RESET(rst), .bus(ia.master));
  oam_dma_engine #(.LENGTH(4), .START_DELAY(3))
    dut_b (.I_CLK(clk), .I_RESET(rst), .bus(ib.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle stamp, sampled only on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  // router read model
  always @(posedge clk) begin
    if (!ia.O_RDMA_RE_L) ia.I_RDMA_DATA <= ia.O_RDMA_ADDR[7:0] ^ 8'h5A;
    if (!ib.O_RDMA_RE_L) ib.I_RDMA_DATA <= ib.O_RDMA_ADDR[7:0] ^ 8'h5A;
  end

  // bus event log
  always @(negedge clk) if (!rst) begin
    if (!ia.O_RDMA_RE_L) rda.push_back(ev_t'{cyc, ia.O_RDMA_ADDR, 8'h00});
    if (!ia.O_WDMA_WE_L) wra.push_back(ev_t'{cyc, ia.O_WDMA_ADDR, ia.O_WDMA_DATA});
    if (ia.O_DMA_DONE) dna.push_back(cyc);
    if (ia.O_DMA_ACTIVE) act_a++;
    if (!ib.O_RDMA_RE_L) rdb.push_back(ev_t'{cyc, ib.O_RDMA_ADDR, 8'h00});
    if (!ib.O_WDMA_WE_L) wrb.push_back(ev_t'{cyc, ib.O_WDMA_ADDR, ib.O_WDMA_DATA});
    if (ib.O_DMA_DONE) dnb.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rda.delete(); wra.delete(); dna.delete();
    rdb.delete(); wrb.delete(); dnb.delete();
    act_a = 0;
  endtask

  // call at a falling edge; the next rising edge is cycle 0, returns in cycle 1
  task automatic trig(input bit use_b, input logic [15:0] a, input logic [7:0] d);
    if (use_b) begin
      ib.I_IOREG_ADDR = a; ib.I_IOREG_DATA = d; ib.I_IOREG_WE_L = 1'b0;
    end else begin
      ia.I_IOREG_ADDR = a; ia.I_IOREG_DATA = d; ia.I_IOREG_WE_L = 1'b0;
    end
    t0 = cyc;
    @(negedge clk);
    ia.I_IOREG_WE_L = 1'b1;
    ib.I_IOREG_WE_L = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " re_l"},   ia.O_RDMA_RE_L,  1);
    check({tag, " we_l"},   ia.O_WDMA_WE_L,  1);
    check({tag, " raddr"},  ia.O_RDMA_ADDR,  0);
    check({tag, " waddr"},  ia.O_WDMA_ADDR,  0);
    check({tag, " wdata"},  ia.O_WDMA_DATA,  0);
    check({tag, " active"}, ia.O_DMA_ACTIVE, 0);
    check({tag, " done"},   ia.O_DMA_DONE,   0);
    check({tag, " dmareg"}, ia.O_DMA_REG,    0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; act_a = 0;
    rst = 1'b1;
    ia.I_IOREG_ADDR = 16'h0; ia.I_IOREG_DATA = 8'h0; ia.I_IOREG_WE_L = 1'b1;
    ib.I_IOREG_ADDR = 16'h0; ib.I_IOREG_DATA = 8'h0; ib.I_IOREG_WE_L = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full 160-byte copy from 0xC100
    clear_log();
    trig(1'b0, 16'hFF46, 8'hC1);
    repeat (170) @(negedge clk);
    check("t1 rd count", rda.size(), 160);
    check("t1 wr count", wra.size(), 160);
    for (int i = 0; i < 160; i++) begin
      check("t1 rd addr", rda[i].a, 32'(16'hC100 + 16'(i)));
      check("t1 rd cyc",  rda[i].c - t0, 2 + i);
      check("t1 wr addr", wra[i].a, 32'(16'hFE00 + 16'(i)));
      check("t1 wr data", wra[i].d, 32'(8'(i) ^ 8'h5A));
      check("t1 wr cyc",  wra[i].c - t0, 4 + i);
    end
    check("t1 done count", dna.size(), 1);
    check("t1 done cyc", dna.size() > 0 ? dna[0] - t0 : -1, 164);
    check("t1 active cycles", act_a, 163);
    check("t1 dma_reg", ia.O_DMA_REG, 8'hC1);

    // echo-RAM source
    clear_log();
    trig(1'b0, 16'hFF46, 8'hE3);
    repeat (170) @(negedge clk);
    check("t2 rd addr0", rda.size() > 0 ? rda[0].a : 16'h0, 16'hC300);
    check("t2 wr count", wra.size(), 160);
    check("t2 last wr", wra.size() == 160 ? wra[159].a : 16'h0, 16'hFE9F);
    check("t2 dma_reg", ia.O_DMA_REG, 8'hE3);

    // retrigger while read index 20 is on the bus (cycle 22)
    clear_log();
    trig(1'b0, 16'hFF46, 8'hC1);
    t1 = t0;
    repeat (21) @(negedge clk);
    trig(1'b0, 16'hFF46, 8'h80);
    repeat (170) @(negedge clk);
    check("t3 retrig cyc", t0 - t1, 22);
    check("t3 rd count", rda.size(), 181);
    check("t3 rd20 addr", rda.size() > 21 ? rda[20].a : 16'h0, 16'hC114);
    check("t3 new rd addr", rda.size() > 21 ? rda[21].a : 16'h0, 16'h8000);
    check("t3 new rd cyc", rda.size() > 21 ? rda[21].c - t0 : -1, 2);
    check("t3 wr count", wra.size(), 179);
    check("t3 old last wr", wra.size() > 19 ? wra[18].a : 16'h0, 16'hFE12);
    check("t3 new wr addr", wra.size() > 19 ? wra[19].a : 16'h0, 16'hFE00);
    check("t3 new wr cyc", wra.size() > 19 ? wra[19].c - t0 : -1, 4);
    check("t3 final wr", wra.size() == 179 ? wra[178].a : 16'h0, 16'hFE9F);
    check("t3 done count", dna.size(), 1);
    check("t3 done cyc", dna.size() > 0 ? dna[0] - t0 : -1, 164);
    check("t3 active cycles", act_a, 185);

    // other address and IO read are ignored
    clear_log();
    ia.I_IOREG_ADDR = 16'hFF47; ia.I_IOREG_DATA = 8'h12; ia.I_IOREG_WE_L = 1'b0;
    @(negedge clk);
    ia.I_IOREG_ADDR = 16'hFF46; ia.I_IOREG_WE_L = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("t4 rd count", rda.size(), 0);
    check("t4 active", act_a, 0);
    check("t4 dma_reg", ia.O_DMA_REG, 8'h80);

    // short instance: source 0xFF, then retrigger in the DONE cycle
    clear_log();
    trig(1'b1, 16'hFF46, 8'hFF);
    t1 = t0;
    repeat (9) @(negedge clk);
    trig(1'b1, 16'hFF46, 8'h01);
    repeat (30) @(negedge clk);
    check("t5 retrig cyc", t0 - t1, 10);
    check("t5 rd count", rdb.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check("t5 rd addr", rdb[i].a, 32'(16'hDF00 + 16'(i)));
      check("t5 rd cyc",  rdb[i].c - t1, 4 + i);
      check("t5 wr addr", wrb[i].a, 32'(16'hFE00 + 16'(i)));
      check("t5 wr data", wrb[i].d, 32'(8'(i) ^ 8'h5A));
      check("t5 wr cyc",  wrb[i].c - t1, 6 + i);
    end
    check("t5 done count", dnb.size(), 2);
    check("t5 done0 cyc", dnb.size() > 0 ? dnb[0] - t1 : -1, 10);
    check("t5 done1 cyc", dnb.size() > 1 ? dnb[1] - t0 : -1, 10);
    check("t5 2nd rd addr", rdb.size() > 4 ? rdb[4].a : 16'h0, 16'h0100);
    check("t5 2nd rd cyc", rdb.size() > 4 ? rdb[4].c - t0 : -1, 4);

    // asynchronous reset during the write of index 50 (cycle 54)
    clear_log();
    trig(1'b0, 16'hFF46, 8'hC1);
    repeat (53) @(negedge clk);
    #1;
    check("t6 wr before rst", wra.size(), 51);
    check("t6 wr idx50 low", ia.O_WDMA_WE_L, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6 async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
    repeat (20) @(negedge clk);
    check("t6 rd after rst", rda.size(), 0);
    check("t6 wr after rst", wra.size(), 0);
    check("t6 active after rst", act_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
